// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
// Owns the PC, drives the instruction memory address and resolves the next PC
// from exception entry, eret, and branch/jump decode in ID.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        id_beq,
  input  logic        id_bne,
  input  logic        id_j,
  input  logic        id_jr,
  input  logic        id_cmp_eq,
  input  logic [31:0] id_jr_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] if_pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        br_taken;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  // Decode bits coming out of a bubble are never trusted, hence the valid qualifier.
  assign br_taken = valid_q & ((id_beq & id_cmp_eq) | (id_bne & ~id_cmp_eq));
  assign redirect = br_taken | (valid_q & (id_j | id_jr));

  // Select the redirect target for whichever control-transfer kind ID decoded.
  always_comb begin
    target = pc4_q + br_off;
    if (id_jr) begin
      target = id_jr_target;
    end else if (id_j) begin
      target = {pc4_q[31:28], inst_q[25:0], 2'b00};
    end
  end

  // Next-state priority: exception, eret, stall, redirect, fetch miss, normal fetch.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      inst_d  = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (eret) begin
      pc_d    = epc & ~32'h3;
      inst_d  = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (stall) begin
      // Hold everything; a pending redirect is re-evaluated once stall drops.
      pc_d = pc_q;
    end else if (redirect) begin
      // The wrong-path word in IF is squashed: no delay slot.
      pc_d    = target & ~32'h3;
      inst_d  = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!imem_ready) begin
      inst_d  = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      inst_d  = imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID register; reset clears the pipeline register to a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        id_beq, id_bne, id_j, id_jr, id_cmp_eq;
  logic [31:0] id_jr_target;
  logic        exc_req, eret;
  logic [31:0] epc;
  logic [31:0] if_pc, if_id_inst, if_id_pc4;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_ready   (imem_ready),
    .id_beq       (id_beq),
    .id_bne       (id_bne),
    .id_j         (id_j),
    .id_jr        (id_jr),
    .id_cmp_eq    (id_cmp_eq),
    .id_jr_target (id_jr_target),
    .exc_req      (exc_req),
    .eret         (eret),
    .epc          (epc),
    .if_pc        (if_pc),
    .if_id_inst   (if_id_inst),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  // Control bit positions: {stall, ready, beq, bne, j, jr, cmp_eq, exc, eret}
  localparam logic [8:0] S    = 9'h100;
  localparam logic [8:0] R    = 9'h080;
  localparam logic [8:0] BEQ  = 9'h040;
  localparam logic [8:0] BNE  = 9'h020;
  localparam logic [8:0] J    = 9'h010;
  localparam logic [8:0] JR   = 9'h008;
  localparam logic [8:0] EQ   = 9'h004;
  localparam logic [8:0] EXC  = 9'h002;
  localparam logic [8:0] ERET = 9'h001;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] data;
    logic [31:0] jrt;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [8:0] ctl, logic [31:0] data, logic [31:0] jrt,
                              logic [31:0] ep, logic [31:0] e_pc, logic [31:0] e_inst,
                              logic [31:0] e_pc4, logic e_v);
    vec_t v;
    v.ctl = ctl; v.data = data; v.jrt = jrt; v.epc = ep;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4; v.e_v = e_v;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                           input logic [31:0] e_pc4, input logic e_v);
    chk({tag, " imem_addr"}, imem_addr, e_pc);
    chk({tag, " if_pc"}, if_pc, e_pc);
    chk({tag, " if_id_inst"}, if_id_inst, e_inst);
    chk({tag, " if_id_pc4"}, if_id_pc4, e_pc4);
    chk({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, e_v});
  endtask

  task automatic drive(input vec_t v);
    {stall, imem_ready, id_beq, id_bne, id_j, id_jr, id_cmp_eq, exc_req, eret} = v.ctl;
    imem_data    = v.data;
    id_jr_target = v.jrt;
    epc          = v.epc;
  endtask

  initial begin
    vec_t idle;
    idle = '{ctl: 9'h0, data: 32'h0, jrt: 32'h0, epc: 32'h0,
             e_pc: 32'h0, e_inst: 32'h0, e_pc4: 32'h0, e_v: 1'b0};

    // Sequential fetch after reset
    add(R,           32'hA0,       0, 0, 32'h4,        32'hA0,       32'h4,        1);
    add(R,           32'hA1,       0, 0, 32'h8,        32'hA1,       32'h8,        1);
    add(R,           32'hA2,       0, 0, 32'hC,        32'hA2,       32'hC,        1);
    add(R,           32'hA3,       0, 0, 32'h10,       32'hA3,       32'h10,       1);
    // jr with misaligned target, low bits cleared
    add(R|JR,        32'hDEAD,     32'h1F, 0, 32'h1C,  0,            0,            0);
    add(R,           32'h1000FFFF, 0, 0, 32'h20,       32'h1000FFFF, 32'h20,       1);
    // beq taken, offset -1: 0x20 - 4
    add(R|BEQ|EQ,    32'hDEAD,     0, 0, 32'h1C,       0,            0,            0);
    add(R,           32'h1000FFFF, 0, 0, 32'h20,       32'h1000FFFF, 32'h20,       1);
    // beq not taken
    add(R|BEQ,       32'hB8,       0, 0, 32'h24,       32'hB8,       32'h24,       1);
    add(R|JR,        32'hDEAD,     32'h4000000C, 0, 32'h4000000C, 0, 0,            0);
    add(R,           32'h08000100, 0, 0, 32'h40000010, 32'h08000100, 32'h40000010, 1);
    // j keeps upper nibble of pc4
    add(R|J,         32'hDEAD,     0, 0, 32'h40000400, 0,            0,            0);
    // j decode on a bubble is ignored
    add(R|J,         32'hC0,       0, 0, 32'h40000404, 32'hC0,       32'h40000404, 1);
    add(R|JR,        32'hDEAD,     32'h123, 0, 32'h120, 0,           0,            0);
    add(R,           32'h14000005, 0, 0, 32'h124,      32'h14000005, 32'h124,      1);
    // taken bne held off by stall
    add(S|R|BNE,     32'hDEAD,     0, 0, 32'h124,      32'h14000005, 32'h124,      1);
    add(S|R|BNE,     32'hDEAD,     0, 0, 32'h124,      32'h14000005, 32'h124,      1);
    add(S|R|BNE,     32'hDEAD,     0, 0, 32'h124,      32'h14000005, 32'h124,      1);
    add(R|BNE,       32'hDEAD,     0, 0, 32'h138,      0,            0,            0);
    add(R,           32'hD0,       0, 0, 32'h13C,      32'hD0,       32'h13C,      1);
    // exception beats stall, redirect and imem_ready=0
    add(EXC|S|J,     32'hDEAD,     0, 0, 32'h8,        0,            0,            0);
    add(R,           32'hE0,       0, 0, 32'hC,        32'hE0,       32'hC,        1);
    // eret beats stall, epc low bits cleared
    add(S|ERET,      32'hDEAD,     0, 32'h47, 32'h44,  0,            0,            0);
    add(9'h0,        32'hDEAD,     0, 0, 32'h44,       0,            0,            0);
    add(J,           32'hDEAD,     0, 0, 32'h44,       0,            0,            0);
    add(R,           32'hF0,       0, 0, 32'h48,       32'hF0,       32'h48,       1);
    // wrap-around
    add(R|JR,        32'hDEAD,     32'hFFFFFFFF, 0, 32'hFFFFFFFC, 0, 0,            0);
    add(R,           32'hF1,       0, 0, 32'h0,        32'hF1,       32'h0,        1);
    // fetch miss while IF/ID is valid turns into a bubble
    add(9'h0,        32'hDEAD,     0, 0, 32'h0,        0,            0,            0);
    add(R,           32'hF2,       0, 0, 32'h4,        32'hF2,       32'h4,        1);

    drive(idle);
    rst = 1'b1;
    #2;
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_v);
    end

    // Mid-run asynchronous reset takes effect without a clock edge
    drive(idle);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk_state("rst_held", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
    imem_data  = 32'h11;
    @(posedge clk);
    #1;
    chk_state("first_fetch", 32'h4, 32'h11, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
